// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types: widths, PC/instruction typedefs,
// branch prediction bundle and the fetch queue entry.
package BasicTypes;

  localparam int ADDR_WIDTH = 32;
  localparam int INSN_WIDTH = 32;

  localparam logic RESET = 1'b0;

  typedef logic [ADDR_WIDTH-1:0] PC;
  typedef logic [INSN_WIDTH-1:0] Instruction;

  typedef struct packed {
    logic taken;
    PC    target;
  } BranchPredict;

  typedef struct packed {
    PC            pc;
    Instruction   instruction;
    BranchPredict branchPredict;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries, one synchronous write
// port and one asynchronous read port, no reset.
import BasicTypes::*;

module fetch_queue_mem #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  FetchQueueEntry       wdata,
  input  logic [PTR_WIDTH-1:0] raddr,
  output FetchQueueEntry       rdata
);

  FetchQueueEntry mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: pointer and occupancy
// control around fetch_queue_mem, flush and async reset.
import BasicTypes::*;

module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enqValid,
  input  PC                  enqPc,
  input  Instruction         enqInstruction,
  input  BranchPredict       enqBranchPredict,
  output logic               enqReady,
  output logic               deqValid,
  output PC                  deqPc,
  output Instruction         deqInstruction,
  output BranchPredict       deqBranchPredict,
  input  logic               deqReady,
  output logic [PTR_WIDTH:0] count
);

  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0] rdPtr;
  logic [PTR_WIDTH-1:0] wrPtr;
  logic                 doEnq;
  logic                 doDeq;
  FetchQueueEntry       wrEntry;
  FetchQueueEntry       head;

  // Occupancy alone decides full/empty; pointers may be equal in both.
  assign enqReady = (count != FULL);
  assign deqValid = (count != '0);

  assign doEnq = enqValid & enqReady & ~flush;
  assign doDeq = deqValid & deqReady & ~flush;

  assign wrEntry = '{
    pc:            enqPc,
    instruction:   enqInstruction,
    branchPredict: enqBranchPredict
  };

  fetch_queue_mem #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (doEnq),
    .waddr (wrPtr),
    .wdata (wrEntry),
    .raddr (rdPtr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doEnq) begin
        wrPtr <= PTR_WIDTH'(wrPtr + 1'b1);
      end
      if (doDeq) begin
        rdPtr <= PTR_WIDTH'(rdPtr + 1'b1);
      end
      unique case ({doEnq, doDeq})
        2'b10:   count <= (PTR_WIDTH+1)'(count + 1'b1);
        2'b01:   count <= (PTR_WIDTH+1)'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Stale storage stays behind an empty queue; show a bubble instead.
  assign deqPc            = deqValid ? head.pc            : '0;
  assign deqInstruction   = deqValid ? head.instruction   : '0;
  assign deqBranchPredict = deqValid ? head.branchPredict : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected PCs,
// a negedge monitor pops and compares every consumed head entry.
import BasicTypes::*;

module tb_fetch_queue;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         enqValid;
  PC            enqPc;
  Instruction   enqInstruction;
  BranchPredict enqBranchPredict;
  logic         enqReady;
  logic         deqValid;
  PC            deqPc;
  Instruction   deqInstruction;
  BranchPredict deqBranchPredict;
  logic         deqReady;
  logic [2:0]   count;

  int errors = 0;
  int checks = 0;
  PC  exp_q[$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .enqValid         (enqValid),
    .enqPc            (enqPc),
    .enqInstruction   (enqInstruction),
    .enqBranchPredict (enqBranchPredict),
    .enqReady         (enqReady),
    .deqValid         (deqValid),
    .deqPc            (deqPc),
    .deqInstruction   (deqInstruction),
    .deqBranchPredict (deqBranchPredict),
    .deqReady         (deqReady),
    .count            (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic Instruction insn_of(PC pc);
    return 32'h1300_0000 | pc;
  endfunction

  function automatic BranchPredict bp_of(PC pc);
    BranchPredict b;
    b.taken  = pc[2];
    b.target = pc + 32'h100;
    return b;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(PC pc);
    enqValid         = 1'b1;
    enqPc            = pc;
    enqInstruction   = insn_of(pc);
    enqBranchPredict = bp_of(pc);
  endtask

  task automatic idle_enq();
    enqValid         = 1'b0;
    enqPc            = '0;
    enqInstruction   = '0;
    enqBranchPredict = '0;
  endtask

  // Monitor: consumption happens at the next posedge.
  always @(negedge clk) begin
    if (rst !== RESET) begin
      chk("count_bound", 64'(count <= 3'd4), 64'd1);
      if (deqValid && deqReady && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_deq", 64'(deqPc), 64'hFFFF_FFFF);
        end else begin
          PC e;
          e = exp_q.pop_front();
          chk("deq_pc", 64'(deqPc), 64'(e));
          chk("deq_insn", 64'(deqInstruction), 64'(insn_of(e)));
          chk("deq_bp", 64'(deqBranchPredict), 64'(bp_of(e)));
        end
      end
    end
  end

  bit en_t [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  bit dq_t [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
  int cnt_t[8] = '{1, 2, 2, 2, 2, 2, 1, 0};

  initial begin
    rst      = RESET;
    flush    = 1'b0;
    deqReady = 1'b0;
    idle_enq();
    tick();
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_enq_ready", 64'(enqReady), 64'd1);
    chk("rst_deq_valid", 64'(deqValid), 64'd0);
    chk("rst_deq_pc", 64'(deqPc), 64'd0);
    tick();
    rst = ~RESET;

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      drive_enq(PC'(4 * i));
      exp_q.push_back(PC'(4 * i));
      tick();
    end
    idle_enq();
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_enq_ready", 64'(enqReady), 64'd0);
    chk("full_head_pc", 64'(deqPc), 64'h0);

    // Blocked fifth enqueue, then drain.
    drive_enq(32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("blocked_count", 64'(count), 64'd4);
    end
    tick();
    deqReady = 1'b1;
    tick();
    exp_q.push_back(32'h10);
    tick();
    idle_enq();
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_sb", 64'(exp_q.size()), 64'd0);
    tick();

    // Streaming: one per cycle, no bypass.
    deqReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_enq(PC'(4 * i));
      exp_q.push_back(PC'(4 * i));
      @(negedge clk);
      chk("stream_valid", 64'(deqValid), (i == 0) ? 64'd0 : 64'd1);
      chk("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      tick();
    end
    idle_enq();
    tick();
    @(negedge clk);
    chk("stream_count_end", 64'(count), 64'd0);
    chk("stream_sb", 64'(exp_q.size()), 64'd0);
    tick();

    // Flush beats a simultaneous enqueue and dequeue.
    deqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(PC'(32'h40 + 4 * i));
      exp_q.push_back(PC'(32'h40 + 4 * i));
      tick();
    end
    @(negedge clk);
    chk("preflush_count", 64'(count), 64'd3);
    tick();
    drive_enq(32'h4C);
    flush    = 1'b1;
    deqReady = 1'b1;
    tick();
    flush    = 1'b0;
    deqReady = 1'b0;
    idle_enq();
    exp_q.delete();
    @(negedge clk);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deqValid), 64'd0);
    chk("flush_pc", 64'(deqPc), 64'd0);
    chk("flush_insn", 64'(deqInstruction), 64'd0);
    chk("flush_bp", 64'(deqBranchPredict), 64'd0);
    tick();

    // Wrap-around with interleaved traffic.
    for (int i = 0; i < 8; i++) begin
      if (en_t[i]) begin
        drive_enq(PC'(32'h80 + 4 * i));
        exp_q.push_back(PC'(32'h80 + 4 * i));
      end else begin
        idle_enq();
      end
      deqReady = dq_t[i];
      tick();
      @(negedge clk);
      chk("wrap_count", 64'(count), 64'(cnt_t[i]));
    end
    idle_enq();
    deqReady = 1'b0;
    chk("wrap_sb", 64'(exp_q.size()), 64'd0);
    tick();

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 2; i++) begin
      drive_enq(PC'(32'hA0 + 4 * i));
      exp_q.push_back(PC'(32'hA0 + 4 * i));
      tick();
    end
    idle_enq();
    @(negedge clk);
    chk("prerst_count", 64'(count), 64'd2);
    tick();
    #1;
    rst = RESET;
    #1;
    chk("arst_valid", 64'(deqValid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_enq_ready", 64'(enqReady), 64'd1);
    exp_q.delete();
    tick();
    rst = ~RESET;

    drive_enq(32'hB0);
    exp_q.push_back(32'hB0);
    deqReady = 1'b1;
    tick();
    idle_enq();
    tick();
    @(negedge clk);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("final_sb", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and rst; reset is asserted when rst equals the package constant RESET.
REQ-002 Parameter DEPTH, default 4: number of queue entries; power of two, minimum 2.
REQ-003 Parameter PTR_WIDTH, default $clog2(DEPTH): width of the read and write pointers.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous reset, active when rst equals RESET.
REQ-006 flush  input  1  discards all entries (controller fetch/decode flush).
REQ-007 enqValid  input  1  the fetch stage presents a valid instruction this cycle.
REQ-008 enqPc  input  ADDR_WIDTH  PC of the enqueued instruction.
REQ-009 enqInstruction  input  INSN_WIDTH  fetched instruction word.
REQ-010 enqBranchPredict  input  $bits(BranchPredict)  BTB/direction prediction attached to the instruction.
REQ-011 enqReady  output  1  the queue can accept an entry this cycle; the fetch stage stalls when this is low.
REQ-012 deqValid  output  1  the head entry is valid.
REQ-013 deqPc, deqInstruction, deqBranchPredict  output  same widths as enq*  contents of the head entry.
REQ-014 deqReady  input  1  the decode stage consumes the head entry this cycle.
REQ-015 count  output  PTR_WIDTH+1  number of occupied entries.

Function
REQ-016 An enqueue SHALL occur on a rising edge when enqValid=1, enqReady=1 and flush=0.
REQ-017 A dequeue SHALL occur on a rising edge when deqValid=1, deqReady=1 and flush=0.
REQ-018 enqReady SHALL equal (count != DEPTH); it SHALL NOT depend combinationally on deqReady.
REQ-019 deqValid SHALL equal (count != 0); the deq* outputs SHALL be driven from the storage entry at the read pointer.
REQ-020 There SHALL be no empty-queue bypass: an entry enqueued at edge N SHALL first be visible on deq* after edge N.
REQ-021 When the queue is empty, deq* SHALL be all-zero, so that a downstream stage sees a bubble.
REQ-022 Pointers SHALL wrap modulo DEPTH. Full and empty SHALL be distinguished by count, never by pointer equality alone.
REQ-023 On a simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 When flush=1 on an edge, count and both pointers SHALL become 0. Any enqueue or dequeue in that cycle SHALL be ignored; flush has priority.
REQ-025 Storage contents SHALL NOT be cleared on flush. Visibility of entries is controlled only through count.
REQ-026 enqValid=1 with enqReady=0 SHALL leave the queue state unchanged; the fetch stage is responsible for holding its inputs.
REQ-027 Dequeue-to-refill throughput SHALL be one entry per cycle in both directions while the queue is neither full nor empty.

Reset
REQ-028 On reset, count, the read pointer and the write pointer SHALL be 0. As a result enqReady=1, deqValid=0 and deq*=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately (asynchronous) and discard all entries. Storage need not be reset.

Structure
REQ-030 ADDR_WIDTH, INSN_WIDTH, the PC and Instruction typedefs, the BranchPredict struct and RESET SHALL come from BasicTypes. A FetchQueueEntry struct {pc, instruction, branchPredict} SHALL be added to BasicTypes.
REQ-031 Storage SHALL be a single sub-module, fetch_queue_mem: a DEPTH x FetchQueueEntry register file with one synchronous write port and one asynchronous read port. Pointer and count logic SHALL remain in fetch_queue.

Verification
REQ-032 Reset, then 4 enqueues of PCs 0x00, 0x04, 0x08, 0x0C with deqReady=0 -> count=4, enqReady=0, deqPc=0x00.
REQ-033 Full queue with a fifth enqValid (PC 0x10) held for 3 cycles -> count stays 4 and PC 0x10 is never dequeued until space frees.
REQ-034 Continuous enqueue and dequeue of 10 entries from empty -> outputs PCs 0x00..0x24 in order, with a 1-cycle initial latency, then one per cycle, and count<=1.
REQ-035 count=3, then flush=1 together with enqValid=1 and deqReady=1 -> next cycle count=0, deqValid=0 and deq*=0; the cycle-of-flush entry is lost.
REQ-036 Wrap-around: 6 enqueues interleaved with 6 dequeues at DEPTH=4 -> FIFO order preserved across pointer wrap, and count never exceeds 4.
REQ-037 Assert rst=0 asynchronously mid-cycle with count=2 -> deqValid falls before the next edge and count=0.
